// File: rtl/fp_align_pipe.sv
// ----------------------------------------------------------------------------
// fp_align_pipe
//
// Two-stage operand alignment front end for a floating-point adder.
//   S1: compares the magnitudes of the two operands and swaps them so that the
//       larger one comes first. It also forms the effective exponents, the
//       hidden bits and the exponent difference.
//   S2: shifts the smaller mantissa right by the exponent difference. Every
//       bit shifted out is ORed into a sticky bit at position 0.
// A valid/ready handshake sits on each side. Each stage moves forward when
// the stage after it is empty or is draining, so the pipe accepts one
// operation per cycle while out_ready is high.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   flush             synchronous kill of both stages (drops this cycle's input)
//   in_valid/in_ready input handshake
//   in_op, in_rd      funct5 and destination tag, carried through unchanged
//   in_a, in_b        operands {sign, exp, frac}
//   out_valid/out_ready output handshake
//   out_op, out_rd    registered op / tag
//   out_exp           effective exponent of the larger operand
//   out_mant_max      {hidden, frac, 3'b000} of the larger operand
//   out_mant_min      smaller mantissa, aligned, sticky in bit 0
//   out_sign_max      sign of the larger operand (b's sign negated for FSUB)
//   out_sign_xor      sign_a ^ sign_b
//   out_eff_sub       sign_a ^ sign_b ^ (op == FSUB)
//   out_swap          in_b was the larger operand
// ----------------------------------------------------------------------------
module fp_align_pipe #(
    parameter  int EXP_W  = 8,
    parameter  int FRAC_W = 23,
    localparam int W      = 1 + EXP_W + FRAC_W,
    localparam int M      = FRAC_W + 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rd,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_op,
    output logic [4:0]       out_rd,
    output logic [EXP_W-1:0] out_exp,
    output logic [M-1:0]     out_mant_max,
    output logic [M-1:0]     out_mant_min,
    output logic             out_sign_max,
    output logic             out_sign_xor,
    output logic             out_eff_sub,
    output logic             out_swap
);

    localparam logic [4:0] OP_FSUB = 5'b00001;

    typedef struct packed {
        logic [4:0]       op;
        logic [4:0]       rd;
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] diff;
        logic [M-1:0]     mant_max;
        logic [M-1:0]     mant_min;
        logic             sign_max;
        logic             sign_xor;
        logic             eff_sub;
        logic             swap;
    } s1_t;

    typedef struct packed {
        logic [4:0]       op;
        logic [4:0]       rd;
        logic [EXP_W-1:0] exp;
        logic [M-1:0]     mant_max;
        logic [M-1:0]     mant_min;
        logic             sign_max;
        logic             sign_xor;
        logic             eff_sub;
        logic             swap;
    } s2_t;

    logic s1_valid, s2_valid;
    logic advance1, advance2;
    s1_t  s1, s1_next;
    s2_t  s2, s2_next;

    // The handshake is evaluated from the back of the pipe to the front.
    assign advance2 = !s2_valid || out_ready;
    assign advance1 = !s1_valid || advance2;
    assign in_ready = advance1;

    // ------------------------------------------------------------------------
    // S1: magnitude compare, swap, effective exponents, exponent difference
    // ------------------------------------------------------------------------
    logic             swap;
    logic             is_sub;
    logic [W-1:0]     op_max, op_min;
    logic [EXP_W-1:0] exp_max, exp_min, eff_max, eff_min;

    // NOTE: every signal written here gets a value on every path (the defaults
    // come first), so no latches are inferred.
    always_comb begin
        s1_next = '0;
        // Comparing {exp, frac} as one unsigned number orders the magnitudes,
        // because the exponent holds the upper bits. Equal magnitudes keep
        // a as the larger operand.
        swap    = in_b[W-2:0] > in_a[W-2:0];
        is_sub  = (in_op == OP_FSUB);
        op_max  = swap ? in_b : in_a;
        op_min  = swap ? in_a : in_b;
        exp_max = op_max[W-2:FRAC_W];
        exp_min = op_min[W-2:FRAC_W];
        // Subnormals use exponent 1 and have no hidden bit.
        eff_max = (exp_max == '0) ? EXP_W'(1) : exp_max;
        eff_min = (exp_min == '0) ? EXP_W'(1) : exp_min;

        s1_next.op       = in_op;
        s1_next.rd       = in_rd;
        s1_next.exp      = eff_max;
        s1_next.diff     = eff_max - eff_min;  // never negative after the swap
        s1_next.mant_max = {|exp_max, op_max[FRAC_W-1:0], 3'b000};
        s1_next.mant_min = {|exp_min, op_min[FRAC_W-1:0], 3'b000};
        // When b is the larger operand its sign is the one that counts, and
        // FSUB negates b.
        s1_next.sign_max = swap ? (in_b[W-1] ^ is_sub) : in_a[W-1];
        s1_next.sign_xor = in_a[W-1] ^ in_b[W-1];
        s1_next.eff_sub  = in_a[W-1] ^ in_b[W-1] ^ is_sub;
        s1_next.swap     = swap;
    end

    // ------------------------------------------------------------------------
    // S2: alignment shift with sticky collection
    // ------------------------------------------------------------------------
    logic [2*M-1:0] shift_ext;
    logic [31:0]    diff_wide;

    always_comb begin
        s2_next   = '0;
        // Zeros are appended below the mantissa so that the bits shifted out
        // land in the lower half, where they can be ORed into the sticky bit.
        shift_ext = {s1.mant_min, {M{1'b0}}} >> s1.diff;
        diff_wide = 32'(s1.diff);

        s2_next.op       = s1.op;
        s2_next.rd       = s1.rd;
        s2_next.exp      = s1.exp;
        s2_next.mant_max = s1.mant_max;
        s2_next.sign_max = s1.sign_max;
        s2_next.sign_xor = s1.sign_xor;
        s2_next.eff_sub  = s1.eff_sub;
        s2_next.swap     = s1.swap;
        // A shift of M or more leaves only the sticky bit. This case is
        // handled on its own because the extended vector is only 2*M bits
        // wide and would also drop the sticky bit.
        if (diff_wide >= 32'(M)) begin
            s2_next.mant_min = {{(M-1){1'b0}}, |s1.mant_min};
        end else begin
            s2_next.mant_min = {shift_ext[2*M-1:M+1],
                                shift_ext[M] | (|shift_ext[M-1:0])};
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Then every
    // register samples the values that were present before the edge.
    // NOTE: the data registers are reset along with the valid bits, so that
    // all outputs read as zero during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1       <= '0;
            s2       <= '0;
        end else if (flush) begin
            // Flush wins over every transfer. The data registers keep their
            // values, but nothing is marked valid.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (advance1) begin
                s1_valid <= in_valid;
            end
            if (advance2) begin
                s2_valid <= s1_valid;
            end
            if (advance1 && in_valid) begin
                s1 <= s1_next;
            end
            if (advance2 && s1_valid) begin
                s2 <= s2_next;
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_op       = s2.op;
    assign out_rd       = s2.rd;
    assign out_exp      = s2.exp;
    assign out_mant_max = s2.mant_max;
    assign out_mant_min = s2.mant_min;
    assign out_sign_max = s2.sign_max;
    assign out_sign_xor = s2.sign_xor;
    assign out_eff_sub  = s2.eff_sub;
    assign out_swap     = s2.swap;

endmodule
